glitch_sweep: RTL and testbench
===============================

GLITCH_SWEEP -- requirements
Module: glitch_sweep

Interface
REQ-001 SHALL have parameter CNT_W, default 24, width of the attempt counter.
REQ-002 SHALL have port clk, input, 1, single clock for all logic.
REQ-003 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-004 SHALL have port start, input, 1, one-cycle pulse that begins a sweep.
REQ-005 SHALL have port abort, input, 1, stops the sweep.
REQ-006 SHALL have ports delay_start, delay_end and delay_step, input, 16 each, delay sweep range and step.
REQ-007 SHALL have ports width_start, width_end and width_step, input, 8 each, width sweep range and step.
REQ-008 SHALL have port repeats, input, 8, attempts per point; 0 is treated as 1.
REQ-009 SHALL have port mode_in, input, 8, glitch mode for every attempt.
REQ-010 SHALL have port holdoff, input, 16, idle cycles after each attempt completes.
REQ-011 SHALL have port trig_en, input, 1, 1 = each attempt waits for a rising edge on trig.
REQ-012 SHALL have port trig, input, 1, target trigger, already synchronous to clk.
REQ-013 SHALL have port g_ready, input, 1, ready from the glitch generator.
REQ-014 SHALL have ports g_delay, g_width and g_mode, output, 16/8/8, registered parameters to the glitch generator.
REQ-015 SHALL have port g_en, output, 1, one-cycle fire request to the glitch generator.
REQ-016 SHALL have ports busy and done, output, 1 each: busy = not IDLE; done = one-cycle pulse at sweep end.
REQ-017 SHALL have port attempt_cnt, output, CNT_W, number of g_en pulses issued since the last start.

Function
REQ-018 SHALL implement states IDLE, ARM, FIRE, WAIT_RDY, HOLDOFF.
REQ-019 SHALL, in IDLE on start, latch all config inputs, set g_delay=delay_start, g_width=width_start and g_mode=mode_in, clear attempt_cnt and the repeat count, and go to ARM.
REQ-020 SHALL, in ARM, go to FIRE when g_ready=1 and either trig_en=0 or a trig rising edge is seen (trig=1 now, 0 the previous cycle); edges seen while g_ready=0 SHALL be dropped.
REQ-021 SHALL, in FIRE, assert g_en for exactly one cycle, increment attempt_cnt (saturating at all-ones) and go to WAIT_RDY.
REQ-022 SHALL, in WAIT_RDY, ignore g_ready in the first cycle after FIRE, then go to HOLDOFF once g_ready=1.
REQ-023 SHALL, in HOLDOFF, count holdoff cycles (0 means leave next cycle) and then advance the sweep point.
REQ-024 SHALL advance as follows: repeat count+1 < repeats means same point, back to ARM; otherwise clear the repeat count and advance delay (inner loop).
REQ-025 SHALL compute the next delay as g_delay+delay_step in 17 bits; if the step is 0, there is a carry, or the result is > delay_end, delay wraps to delay_start and width advances.
REQ-026 SHALL advance width by the same rule, 9-bit sum against width_end; on width wrap the sweep ends: pulse done for one cycle and go to IDLE.
REQ-027 SHALL treat delay_end < delay_start as the single point delay_start, and likewise for width.
REQ-028 SHALL keep g_delay, g_width and g_mode stable from FIRE until the next advance.
REQ-029 SHALL give abort priority over everything except rst: next cycle state=IDLE, g_en=0, no done pulse, attempt_cnt held.
REQ-030 SHALL ignore start while busy=1; start and abort in the same cycle in IDLE means stay IDLE.
REQ-031 SHALL NOT sample config inputs while busy, so changes mid-sweep have no effect.

Reset
REQ-032 SHALL, on rst=1 at a clk edge, set state=IDLE and g_en, done, busy=0; g_delay, g_width, g_mode and attempt_cnt=0; clear the trig history; this applies mid-sweep too.

Verification
REQ-033 SHALL cover the basic sweep: delay 10..30 step 10, width 2..3 step 1, repeats 1, trig_en 0, model ready -> 6 attempts in order (10,2)(20,2)(30,2)(10,3)(20,3)(30,3), then done pulse, attempt_cnt=6.
REQ-034 SHALL cover repeats: repeats=3, single point delay 5 width 1 -> 3 g_en pulses at (5,1), attempt_cnt=3, then done.
REQ-035 SHALL cover triggering: trig_en=1, trig held high from start, then toggled -> no g_en until the first 0->1 edge; exactly one g_en per edge.
REQ-036 SHALL cover overflow: delay_start=0xFFF0, step 0x20, end 0xFFFF -> one delay point only, no wrap to a low delay.
REQ-037 SHALL cover abort during HOLDOFF with holdoff=100 -> IDLE next cycle, busy=0, no done pulse, g_en stays 0.
REQ-038 SHALL cover rst asserted during WAIT_RDY -> all outputs 0 next cycle, and a following start sweeps normally.

Source files
------------

// File: rtl/glitch_sweep.sv
// glitch_sweep: steps a glitch generator through a 2-D (width x delay) parameter grid.
// Delay is the inner loop and width the outer loop. Each grid point can be repeated.
// Each attempt can optionally wait for a rising edge on the target trigger.
//
// Ports
//   clk, rst          single clock; synchronous active-high reset
//   start, abort      start pulse (ignored while busy); abort returns to IDLE at once
//   delay_*/width_*   sweep ranges and steps, latched on start
//   repeats           attempts per point (0 behaves as 1)
//   mode_in           glitch mode used for every attempt
//   holdoff           extra idle cycles after each attempt completes
//   trig_en, trig     optional per-attempt trigger (trig already synchronous to clk)
//   g_ready           glitch generator ready
//   g_delay/g_width/g_mode, g_en   parameters and one-cycle fire request to the generator
//   busy, done        busy = not IDLE; done = one-cycle pulse at normal sweep end
//   attempt_cnt       g_en pulses since the last start (saturating)
module glitch_sweep #(
    parameter int unsigned CNT_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [15:0]      delay_start,
    input  logic [15:0]      delay_end,
    input  logic [15:0]      delay_step,
    input  logic [7:0]       width_start,
    input  logic [7:0]       width_end,
    input  logic [7:0]       width_step,
    input  logic [7:0]       repeats,
    input  logic [7:0]       mode_in,
    input  logic [15:0]      holdoff,
    input  logic             trig_en,
    input  logic             trig,
    input  logic             g_ready,
    output logic [15:0]      g_delay,
    output logic [7:0]       g_width,
    output logic [7:0]       g_mode,
    output logic             g_en,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] attempt_cnt
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] ARM      = 3'd1;
    localparam logic [2:0] FIRE     = 3'd2;
    localparam logic [2:0] WAIT_RDY = 3'd3;
    localparam logic [2:0] HOLDOFF  = 3'd4;

    logic [2:0]  state;
    logic [15:0] cfg_d_start, cfg_d_end, cfg_d_step;
    logic [7:0]  cfg_w_start, cfg_w_end, cfg_w_step;
    logic [7:0]  cfg_repeats;
    logic [15:0] cfg_holdoff;
    logic        cfg_trig_en;
    logic [7:0]  rep_cnt;
    logic [15:0] hold_cnt;
    logic        trig_q;
    logic        wait_first;

    logic        trig_rise;
    logic [7:0]  rep_eff;
    logic        rep_more;
    logic [16:0] d_sum;
    logic [8:0]  w_sum;
    logic        d_wrap;
    logic        w_wrap;

    always_comb begin
        trig_rise = trig & ~trig_q;
        rep_eff   = (cfg_repeats == 8'd0) ? 8'd1 : cfg_repeats;
        rep_more  = ({1'b0, rep_cnt} + 9'd1) < {1'b0, rep_eff};
        d_sum     = {1'b0, g_delay} + {1'b0, cfg_d_step};
        w_sum     = {1'b0, g_width} + {1'b0, cfg_w_step};
        // A reversed range also wraps here: start + step always exceeds an end below start.
        d_wrap    = (cfg_d_step == 16'd0) || d_sum[16] || (d_sum[15:0] > cfg_d_end);
        w_wrap    = (cfg_w_step == 8'd0) || w_sum[8] || (w_sum[7:0] > cfg_w_end);
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            g_delay     <= '0;
            g_width     <= '0;
            g_mode      <= '0;
            g_en        <= 1'b0;
            done        <= 1'b0;
            attempt_cnt <= '0;
            cfg_d_start <= '0;
            cfg_d_end   <= '0;
            cfg_d_step  <= '0;
            cfg_w_start <= '0;
            cfg_w_end   <= '0;
            cfg_w_step  <= '0;
            cfg_repeats <= '0;
            cfg_holdoff <= '0;
            cfg_trig_en <= 1'b0;
            rep_cnt     <= '0;
            hold_cnt    <= '0;
            trig_q      <= 1'b0;
            wait_first  <= 1'b0;
        end else begin
            trig_q <= trig;
            g_en   <= 1'b0;
            done   <= 1'b0;
            if (abort) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            cfg_d_start <= delay_start;
                            cfg_d_end   <= delay_end;
                            cfg_d_step  <= delay_step;
                            cfg_w_start <= width_start;
                            cfg_w_end   <= width_end;
                            cfg_w_step  <= width_step;
                            cfg_repeats <= repeats;
                            cfg_holdoff <= holdoff;
                            cfg_trig_en <= trig_en;
                            g_delay     <= delay_start;
                            g_width     <= width_start;
                            g_mode      <= mode_in;
                            attempt_cnt <= '0;
                            rep_cnt     <= '0;
                            state       <= ARM;
                        end
                    end
                    ARM: begin
                        // Edges arriving while the generator is not ready are simply lost.
                        if (g_ready && (!cfg_trig_en || trig_rise)) begin
                            g_en  <= 1'b1;
                            state <= FIRE;
                        end
                    end
                    FIRE: begin
                        if (attempt_cnt != {CNT_W{1'b1}}) begin
                            attempt_cnt <= attempt_cnt + CNT_W'(1);
                        end
                        wait_first <= 1'b1;
                        state      <= WAIT_RDY;
                    end
                    WAIT_RDY: begin
                        // g_ready may still show the pre-fire value in the first cycle.
                        if (wait_first) begin
                            wait_first <= 1'b0;
                        end else if (g_ready) begin
                            hold_cnt <= '0;
                            state    <= HOLDOFF;
                        end
                    end
                    HOLDOFF: begin
                        if (hold_cnt != cfg_holdoff) begin
                            hold_cnt <= hold_cnt + 16'd1;
                        end else if (rep_more) begin
                            rep_cnt <= rep_cnt + 8'd1;
                            state   <= ARM;
                        end else begin
                            rep_cnt <= '0;
                            if (!d_wrap) begin
                                g_delay <= d_sum[15:0];
                                state   <= ARM;
                            end else begin
                                g_delay <= cfg_d_start;
                                if (!w_wrap) begin
                                    g_width <= w_sum[7:0];
                                    state   <= ARM;
                                end else begin
                                    g_width <= cfg_w_start;
                                    done    <= 1'b1;
                                    state   <= IDLE;
                                end
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_glitch_sweep.sv
`timescale 1ns/1ps
module tb_glitch_sweep;

    logic        clk = 1'b0;
    logic        rst, start, abort;
    logic [15:0] delay_start, delay_end, delay_step;
    logic [7:0]  width_start, width_end, width_step;
    logic [7:0]  repeats, mode_in;
    logic [15:0] holdoff;
    logic        trig_en, trig, g_ready;
    logic [15:0] g_delay;
    logic [7:0]  g_width, g_mode;
    logic        g_en, busy, done;
    logic [23:0] attempt_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    glitch_sweep #(.CNT_W(24)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .delay_start(delay_start), .delay_end(delay_end), .delay_step(delay_step),
        .width_start(width_start), .width_end(width_end), .width_step(width_step),
        .repeats(repeats), .mode_in(mode_in), .holdoff(holdoff),
        .trig_en(trig_en), .trig(trig), .g_ready(g_ready),
        .g_delay(g_delay), .g_width(g_width), .g_mode(g_mode), .g_en(g_en),
        .busy(busy), .done(done), .attempt_cnt(attempt_cnt)
    );

    // Generator model: busy for a few cycles after each fire request.
    int rdy_cnt = 0;
    always @(posedge clk) begin
        if (g_en) rdy_cnt <= 3;
        else if (rdy_cnt != 0) rdy_cnt <= rdy_cnt - 1;
    end
    assign g_ready = (rdy_cnt == 0);

    // Record every fire request and every done pulse.
    logic [15:0] mon_d[$];
    logic [7:0]  mon_w[$];
    int          done_seen = 0;
    always @(negedge clk) begin
        if (g_en) begin
            mon_d.push_back(g_delay);
            mon_w.push_back(g_width);
        end
        if (done) done_seen++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are read just after the falling edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic set_cfg(input logic [15:0] ds, input logic [15:0] de, input logic [15:0] dst,
                           input logic [7:0] ws, input logic [7:0] we, input logic [7:0] wst,
                           input logic [7:0] rep, input logic [7:0] md, input logic [15:0] ho,
                           input logic te);
        delay_start = ds; delay_end = de; delay_step = dst;
        width_start = ws; width_end = we; width_step = wst;
        repeats = rep; mode_in = md; holdoff = ho; trig_en = te;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, input string tag);
        int k;
        for (k = 0; k < max_cyc; k++) begin
            if (done) break;
            tick(1);
        end
        check_eq(tag, {31'd0, done}, 32'd1);
    endtask

    task automatic wait_fire(input int max_cyc, input string tag);
        int k;
        for (k = 0; k < max_cyc; k++) begin
            if (g_en) break;
            tick(1);
        end
        check_eq(tag, {31'd0, g_en}, 32'd1);
    endtask

    // Compare recorded attempts from index base against expected (delay, width) lists.
    task automatic check_points(input string tag, input int base, input int n,
                                input logic [15:0] ed[6], input logic [7:0] ew[6]);
        check_eq({tag, "_count"}, mon_d.size() - base, n);
        for (int i = 0; i < n; i++) begin
            if (base + i < mon_d.size()) begin
                check_eq($sformatf("%s_delay%0d", tag, i), {16'd0, mon_d[base + i]}, {16'd0, ed[i]});
                check_eq($sformatf("%s_width%0d", tag, i), {24'd0, mon_w[base + i]}, {24'd0, ew[i]});
            end
        end
    endtask

    initial begin
        logic [15:0] ed[6];
        logic [7:0]  ew[6];
        int          base, dbase;

        rst = 1'b1; start = 1'b0; abort = 1'b0; trig = 1'b0;
        set_cfg(16'd0, 16'd0, 16'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 16'd0, 1'b0);
        tick(3);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_g_en", {31'd0, g_en}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_g_delay", {16'd0, g_delay}, 32'd0);
        check_eq("rst_g_width", {24'd0, g_width}, 32'd0);
        check_eq("rst_g_mode", {24'd0, g_mode}, 32'd0);
        check_eq("rst_attempt_cnt", {8'd0, attempt_cnt}, 32'd0);
        rst = 1'b0;
        tick(2);

        // start together with abort in IDLE stays idle
        start = 1'b1; abort = 1'b1;
        tick(1);
        start = 1'b0; abort = 1'b0;
        check_eq("start_abort_busy", {31'd0, busy}, 32'd0);
        tick(2);
        check_eq("start_abort_busy_later", {31'd0, busy}, 32'd0);

        // Basic 3x2 sweep; mid-sweep config changes and a second start must be ignored
        set_cfg(16'd10, 16'd30, 16'd10, 8'd2, 8'd3, 8'd1, 8'd1, 8'h5A, 16'd0, 1'b0);
        base = mon_d.size(); dbase = done_seen;
        pulse_start();
        check_eq("basic_busy", {31'd0, busy}, 32'd1);
        tick(3);
        set_cfg(16'd7, 16'd100, 16'd1, 8'd1, 8'd9, 8'd1, 8'd4, 8'h11, 16'd5, 1'b1);
        pulse_start();
        wait_done(1000, "basic_done");
        check_eq("basic_busy_end", {31'd0, busy}, 32'd0);
        tick(3);
        ed = '{16'd10, 16'd20, 16'd30, 16'd10, 16'd20, 16'd30};
        ew = '{8'd2, 8'd2, 8'd2, 8'd3, 8'd3, 8'd3};
        check_points("basic", base, 6, ed, ew);
        check_eq("basic_cnt", {8'd0, attempt_cnt}, 32'd6);
        check_eq("basic_mode", {24'd0, g_mode}, 32'h5A);
        check_eq("basic_done_pulses", done_seen - dbase, 32'd1);

        // Repeats on a single point
        set_cfg(16'd5, 16'd5, 16'd1, 8'd1, 8'd1, 8'd1, 8'd3, 8'h33, 16'd0, 1'b0);
        base = mon_d.size();
        pulse_start();
        wait_done(500, "rep_done");
        tick(2);
        ed = '{16'd5, 16'd5, 16'd5, 16'd0, 16'd0, 16'd0};
        ew = '{8'd1, 8'd1, 8'd1, 8'd0, 8'd0, 8'd0};
        check_points("rep", base, 3, ed, ew);
        check_eq("rep_cnt", {8'd0, attempt_cnt}, 32'd3);

        // Reversed ranges collapse to the start point; repeats 0 acts as 1
        set_cfg(16'd50, 16'd10, 16'd5, 8'd4, 8'd0, 8'd1, 8'd0, 8'h01, 16'd0, 1'b0);
        base = mon_d.size();
        pulse_start();
        wait_done(500, "rev_done");
        tick(2);
        ed = '{16'd50, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
        ew = '{8'd4, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        check_points("rev", base, 1, ed, ew);
        check_eq("rev_cnt", {8'd0, attempt_cnt}, 32'd1);

        // Delay carry out of 16 bits ends the inner loop; width step 0 is one point
        set_cfg(16'hFFF0, 16'hFFFF, 16'h0020, 8'd7, 8'd20, 8'd0, 8'd1, 8'h02, 16'd0, 1'b0);
        base = mon_d.size();
        pulse_start();
        wait_done(500, "ovf_done");
        tick(2);
        ed = '{16'hFFF0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
        ew = '{8'd7, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        check_points("ovf", base, 1, ed, ew);

        // Trigger: level high at start does not fire, each 0->1 edge fires once
        set_cfg(16'd1, 16'd2, 16'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'h03, 16'd0, 1'b1);
        trig = 1'b1;
        tick(2);
        base = mon_d.size();
        pulse_start();
        tick(20);
        check_eq("trig_none_yet", mon_d.size() - base, 32'd0);
        check_eq("trig_busy", {31'd0, busy}, 32'd1);
        trig = 1'b0;
        tick(2);
        trig = 1'b1;
        tick(20);
        check_eq("trig_one_edge", mon_d.size() - base, 32'd1);
        trig = 1'b0;
        tick(1);
        trig = 1'b1;
        wait_done(100, "trig_done");
        tick(2);
        ed = '{16'd1, 16'd2, 16'd0, 16'd0, 16'd0, 16'd0};
        ew = '{8'd1, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0};
        check_points("trig", base, 2, ed, ew);
        trig = 1'b0;

        // Abort during a long holdoff
        set_cfg(16'd1, 16'd1, 16'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'h04, 16'd100, 1'b0);
        base = mon_d.size(); dbase = done_seen;
        pulse_start();
        wait_fire(50, "abort_fire");
        tick(12);
        check_eq("abort_busy_before", {31'd0, busy}, 32'd1);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        check_eq("abort_busy", {31'd0, busy}, 32'd0);
        check_eq("abort_g_en", {31'd0, g_en}, 32'd0);
        check_eq("abort_done", {31'd0, done}, 32'd0);
        tick(150);
        check_eq("abort_no_done", done_seen - dbase, 32'd0);
        check_eq("abort_no_more_fire", mon_d.size() - base, 32'd1);
        check_eq("abort_cnt_held", {8'd0, attempt_cnt}, 32'd1);

        // Reset while waiting for ready, then a clean sweep
        set_cfg(16'd1, 16'd2, 16'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'hC3, 16'd0, 1'b0);
        pulse_start();
        wait_fire(50, "rstw_fire");
        tick(1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check_eq("rstw_busy", {31'd0, busy}, 32'd0);
        check_eq("rstw_g_en", {31'd0, g_en}, 32'd0);
        check_eq("rstw_done", {31'd0, done}, 32'd0);
        check_eq("rstw_g_delay", {16'd0, g_delay}, 32'd0);
        check_eq("rstw_g_width", {24'd0, g_width}, 32'd0);
        check_eq("rstw_g_mode", {24'd0, g_mode}, 32'd0);
        check_eq("rstw_cnt", {8'd0, attempt_cnt}, 32'd0);
        tick(2);
        base = mon_d.size();
        pulse_start();
        wait_done(500, "rstw_sweep_done");
        tick(2);
        ed = '{16'd1, 16'd2, 16'd0, 16'd0, 16'd0, 16'd0};
        ew = '{8'd1, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0};
        check_points("rstw_sweep", base, 2, ed, ew);
        check_eq("rstw_sweep_cnt", {8'd0, attempt_cnt}, 32'd2);
        check_eq("rstw_sweep_mode", {24'd0, g_mode}, 32'hC3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
